output_port_arbiter: RTL

//  Per-output-port arbiter/scheduler for the NoC router. Collects requests from the NUM_IN

---
 rtl/output_port_arbiter_if.sv | 27 ++
 rtl/output_port_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the NoC input ports and one output-port arbiter.
// The master side supplies requests and flits; the slave side is the arbiter itself.
interface output_port_arbiter_if #(
    parameter int NUM_IN = 5,
    parameter int DSIZE  = 32,
    parameter int CW     = 4
);
    logic [NUM_IN-1:0]       req;
    logic [NUM_IN*DSIZE-1:0] data_in;
    logic                    credit_in;
    logic [NUM_IN-1:0]       pop;
    logic [NUM_IN-1:0]       grant;
    logic [DSIZE-1:0]        data_out;
    logic                    out_valid;
    logic                    busy;
    logic [CW-1:0]           credits;

    modport master (
        output req, data_in, credit_in,
        input  pop, grant, data_out, out_valid, busy, credits
    );

    modport slave (
        input  req, data_in, credit_in,
        output pop, grant, data_out, out_valid, busy, credits
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Output-port scheduler: round-robin packet arbitration, wormhole lock from head to tail,
// winning flit registered onto the link, downstream credit tracking.
module output_port_arbiter #(
    parameter int NUM_IN  = 5,
    parameter int DSIZE   = 32,
    parameter int CREDITS = 4,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output_port_arbiter_if.slave bus
);
    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q;
    logic [IW-1:0]     ptr_q, owner_q, pick_d, ptr_d;
    logic [NUM_IN-1:0] grant_q;
    logic [DSIZE-1:0]  data_q;
    logic              valid_q, busy_q;
    logic [CW-1:0]     credits_q, credits_d;
    logic              pick_vld, xfer;
    logic [DSIZE-1:0]  flit;
    int                idx;

    // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_d   = '0;
        idx      = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_IN;
            if (bus.req[IW'(idx)]) begin
                pick_vld = 1'b1;
                pick_d   = IW'(idx);
            end
        end
    end

    always_comb begin
        flit  = bus.data_in[int'(owner_q)*DSIZE +: DSIZE];
        xfer  = (state_q == BUSY) && bus.req[owner_q] && (credits_q != '0);
        ptr_d = (int'(owner_q) == NUM_IN - 1) ? '0 : owner_q + 1'b1;
        credits_d = credits_q;
        if (xfer && !bus.credit_in)
            credits_d = credits_q - 1'b1;
        else if (!xfer && bus.credit_in && (credits_q < CW'(CREDITS)))
            credits_d = credits_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            credits_q <= CW'(CREDITS);
        end else begin
            credits_q <= credits_d;
            valid_q   <= xfer;
            if (xfer)
                data_q <= flit;
            case (state_q)
                IDLE: if (pick_vld) begin
                    owner_q <= pick_d;
                    grant_q <= NUM_IN'(1) << pick_d;
                    busy_q  <= 1'b1;
                    state_q <= BUSY;
                end
                // Only a transferred tail releases the lock; a head mid-packet is plain data.
                BUSY: if (xfer && (flit[1:0] == 2'b10)) begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pop       = xfer ? (NUM_IN'(1) << owner_q) : '0;
    assign bus.grant     = grant_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.credits   = credits_q;
endmodule
